// File: rtl/fixed_predictor_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fixed_predictor_decoder_if                                                 |
// | Sample-stream bundle between residual decoder and fixed predictor stage.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fixed_predictor_decoder_if #(
  parameter int DATA_W = 16
);
  logic                     iEnable;
  logic [15:0]              iBlockSize;
  logic [2:0]               iOrder;
  logic                     iValid;
  logic signed [DATA_W-1:0] iSample;
  logic signed [DATA_W-1:0] oSample;
  logic                     oValid;
  logic                     oDone;
  logic                     oError;

  modport master (
    output iEnable, iBlockSize, iOrder, iValid, iSample,
    input  oSample, oValid, oDone, oError
  );

  modport slave (
    input  iEnable, iBlockSize, iOrder, iValid, iSample,
    output oSample, oValid, oDone, oError
  );
endinterface
`default_nettype wire

// File: rtl/fixed_predictor_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fixed_predictor_decoder                                                    |
// | FLAC FIXED subframe reconstruction (orders 0-4); define                    |
// | FIXED_PRED_SATURATE_EN to clamp instead of wrapping the result.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fixed_predictor_decoder #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20
) (
  input  logic                  iClock,
  input  logic                  iReset,
  fixed_predictor_decoder_if.slave bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WARMUP   = 2'd1;
  localparam logic [1:0] c_RUN      = 2'd2;
  localparam logic [1:0] c_FINISHED = 2'd3;

  logic [1:0]               r_state;
  logic [2:0]               r_order;
  logic [15:0]              r_blockSize;
  logic [15:0]              r_count;
  logic signed [DATA_W-1:0] r_s1, r_s2, r_s3, r_s4;
  logic signed [DATA_W-1:0] r_sample;
  logic                     r_valid;
  logic                     r_done;
  logic                     r_error;

  logic                     w_accept;
  logic                     w_idle;
  logic                     w_orderLegal;
  logic                     w_badConfig;
  logic [2:0]               w_order;
  logic [15:0]              w_blockSize;
  logic [15:0]              w_countNext;
  logic                     w_isWarmup;
  logic signed [ACC_W-1:0]  w_e1, w_e2, w_e3, w_e4, w_eIn;
  logic signed [ACC_W-1:0]  w_pred;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_result;
  logic signed [DATA_W-1:0] w_outSample;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign w_accept     = bus.iEnable & bus.iValid & (r_state != c_FINISHED);
  assign w_idle       = (r_state == c_IDLE);
  assign w_orderLegal = (bus.iOrder <= 3'd4);
  assign w_badConfig  = !w_orderLegal || (bus.iBlockSize == 16'd0) ||
                        (bus.iBlockSize < {13'd0, bus.iOrder});

  // Configuration comes straight from the ports on the first accepted input.
  assign w_order      = w_idle ? (w_orderLegal ? bus.iOrder : 3'd0) : r_order;
  assign w_blockSize  = w_idle ? bus.iBlockSize : r_blockSize;
  assign w_countNext  = r_count + 16'd1;
  assign w_isWarmup   = ({13'd0, w_order} > r_count);

  assign w_e1  = sext(r_s1);
  assign w_e2  = sext(r_s2);
  assign w_e3  = sext(r_s3);
  assign w_e4  = sext(r_s4);
  assign w_eIn = sext(bus.iSample);

  always_comb begin
    w_pred = '0;
    case (w_order)
      3'd1:    w_pred = w_e1;
      3'd2:    w_pred = (w_e1 <<< 1) - w_e2;
      3'd3:    w_pred = (w_e1 <<< 1) + w_e1 - (w_e2 <<< 1) - w_e2 + w_e3;
      3'd4:    w_pred = (w_e1 <<< 2) - (w_e2 <<< 2) - (w_e2 <<< 1)
                        + (w_e3 <<< 2) - w_e4;
      default: w_pred = '0;
    endcase
  end

  assign w_sum = w_pred + w_eIn;

`ifdef FIXED_PRED_SATURATE_EN
  localparam logic signed [ACC_W-1:0] c_SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    w_result = w_sum[DATA_W-1:0];
    if (w_sum > c_SAT_MAX)
      w_result = c_SAT_MAX[DATA_W-1:0];
    else if (w_sum < c_SAT_MIN)
      w_result = c_SAT_MIN[DATA_W-1:0];
  end
`else
  // Plain wrap keeps bit-exactness with the reference decoder.
  logic w_unusedSumHi;
  assign w_unusedSumHi = ^w_sum[ACC_W-1:DATA_W];
  assign w_result      = w_sum[DATA_W-1:0];
`endif

  assign w_outSample = w_isWarmup ? bus.iSample : w_result;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state     <= c_IDLE;
      r_order     <= 3'd0;
      r_blockSize <= 16'd0;
      r_count     <= 16'd0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_s4        <= '0;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (w_accept) begin
        if (w_idle) begin
          r_order     <= w_order;
          r_blockSize <= bus.iBlockSize;
          if (w_badConfig)
            r_error <= 1'b1;
        end
        if (w_blockSize == 16'd0) begin
          r_state <= c_FINISHED;
        end else begin
          r_valid  <= 1'b1;
          r_sample <= w_outSample;
          r_s1     <= w_outSample;
          r_s2     <= r_s1;
          r_s3     <= r_s2;
          r_s4     <= r_s3;
          r_count  <= w_countNext;
          if (w_countNext == w_blockSize) begin
            r_state <= c_FINISHED;
            r_done  <= 1'b1;
          end else if ({13'd0, w_order} > w_countNext) begin
            r_state <= c_WARMUP;
          end else begin
            r_state <= c_RUN;
          end
        end
      end
    end
  end

  assign bus.oSample = r_sample;
  assign bus.oValid  = r_valid;
  assign bus.oDone   = r_done;
  assign bus.oError  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fixed_predictor_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fixed_predictor_decoder                                                 |
// | Directed table, hand sequences and randomized blocks against a list model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fixed_predictor_decoder;
  localparam int DATA_W = 16;
`ifdef FIXED_PRED_SATURATE_EN
  localparam int c_OVF_EXP = 32767;
`else
  localparam int c_OVF_EXP = -32768;
`endif

  typedef struct {
    int order;
    int bs;
    int n;
    int din[8];
    int dout[8];
    bit err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nCmp = 0;
  int   nBad = 0;

  always #5 clock = ~clock;

  fixed_predictor_decoder_if #(.DATA_W(DATA_W)) bus();

  fixed_predictor_decoder #(.DATA_W(DATA_W), .ACC_W(20)) dut (
    .iClock(clock),
    .iReset(reset),
    .bus   (bus)
  );

  // Reference model: the block as a list of produced samples.
  bit mStarted, mFin, mErr;
  int mOrd, mBs;
  int mOuts[$];
  int coef[5][4] = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, -1, 0, 0},
                     '{3, -3, 1, 0}, '{4, -6, 4, -1}};

  function automatic int fit(input int v);
    logic signed [DATA_W-1:0] t;
`ifdef FIXED_PRED_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    t = v[DATA_W-1:0];
    return int'(t);
  endfunction

  task automatic model_step(input bit en, input bit vld, input int x,
                            output bit eV, output int eS, output bit eD);
    int n, acc;
    eV = 1'b0; eS = 0; eD = 1'b0;
    if (!(en && vld) || mFin) return;
    if (!mStarted) begin
      mStarted = 1'b1;
      mBs  = int'(bus.iBlockSize);
      mOrd = (bus.iOrder > 3'd4) ? 0 : int'(bus.iOrder);
      mErr = (bus.iOrder > 3'd4) || (mBs < int'(bus.iOrder)) || (mBs == 0);
      if (mBs == 0) begin
        mFin = 1'b1;
        return;
      end
    end
    n = mOuts.size();
    acc = x;
    for (int k = 0; k < mOrd; k++)
      if (n >= mOrd) acc += coef[mOrd][k] * mOuts[n-1-k];
    eS = (n < mOrd) ? x : fit(acc);
    mOuts.push_back(eS);
    eV = 1'b1;
    eD = (n + 1 == mBs);
    if (eD) mFin = 1'b1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_check(input bit en, input bit vld, input int x, input bit eV,
                             input int eS, input bit eD, input bit eE, input string tag);
    bus.iEnable = en;
    bus.iValid  = vld;
    bus.iSample = x[DATA_W-1:0];
    @(posedge clock);
    #1;
    check({tag, ".oValid"}, int'(bus.oValid), int'(eV));
    check({tag, ".oDone"},  int'(bus.oDone),  int'(eD));
    check({tag, ".oError"}, int'(bus.oError), int'(eE));
    if (eV) check({tag, ".oSample"}, int'(bus.oSample), eS);
  endtask

  task automatic do_reset(input bit withInput);
    reset = 1'b1;
    bus.iEnable = withInput;
    bus.iValid  = withInput;
    bus.iSample = 16'sd123;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.iValid  = 1'b0;
    bus.iEnable = 1'b1;
    check("reset.oValid",  int'(bus.oValid), 0);
    check("reset.oDone",   int'(bus.oDone),  0);
    check("reset.oError",  int'(bus.oError), 0);
    check("reset.oSample", int'(bus.oSample), 0);
    mStarted = 1'b0; mFin = 1'b0; mErr = 1'b0;
    mOuts.delete();
  endtask

  vec_t vecs[7];
  int   seqIn[6];
  int   seqOut[6];

  initial begin
    bit eV, eD, en, vld;
    int eS, x;
    logic signed [15:0] tmp;

    vecs[0] = '{2, 5, 5, '{10, 20, 0, 1, -5, 0, 0, 0}, '{10, 20, 30, 41, 47, 0, 0, 0}, 1'b0};
    vecs[1] = '{4, 6, 8, '{1, 2, 3, 4, 0, 0, 9, 9}, '{1, 2, 3, 4, 5, 6, 0, 0}, 1'b0};
    vecs[2] = '{0, 3, 3, '{-7, 0, 32767, 0, 0, 0, 0, 0}, '{-7, 0, 32767, 0, 0, 0, 0, 0}, 1'b0};
    vecs[3] = '{1, 2, 2, '{32767, 1, 0, 0, 0, 0, 0, 0}, '{32767, c_OVF_EXP, 0, 0, 0, 0, 0, 0}, 1'b0};
    vecs[4] = '{6, 3, 3, '{5, -3, 100, 0, 0, 0, 0, 0}, '{5, -3, 100, 0, 0, 0, 0, 0}, 1'b1};
    vecs[5] = '{3, 2, 3, '{7, 8, 9, 0, 0, 0, 0, 0}, '{7, 8, 0, 0, 0, 0, 0, 0}, 1'b1};
    vecs[6] = '{2, 0, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1};

    bus.iEnable = 1'b0; bus.iValid = 1'b0; bus.iSample = '0;
    bus.iOrder = 3'd0; bus.iBlockSize = 16'd0;

    for (int r = 0; r < 7; r++) begin
      do_reset(1'b0);
      bus.iOrder     = 3'(vecs[r].order);
      bus.iBlockSize = 16'(vecs[r].bs);
      for (int i = 0; i < vecs[r].n; i++)
        drive_check(1'b1, 1'b1, vecs[r].din[i], (i < vecs[r].bs), vecs[r].dout[i],
                    (i == vecs[r].bs - 1), vecs[r].err, $sformatf("vec%0d[%0d]", r, i));
    end

    // Enable gap after the 4th input of an order-3 block.
    seqIn  = '{5, -2, 8, 1, 3, -4};
    seqOut = '{5, -2, 8, 36, 85, 151};
    do_reset(1'b0);
    bus.iOrder = 3'd3; bus.iBlockSize = 16'd6;
    for (int i = 0; i < 4; i++)
      drive_check(1'b1, 1'b1, seqIn[i], 1'b1, seqOut[i], 1'b0, 1'b0, $sformatf("gap[%0d]", i));
    for (int i = 0; i < 3; i++)
      drive_check(1'b0, 1'b1, 999, 1'b0, 0, 1'b0, 1'b0, $sformatf("gapOff[%0d]", i));
    for (int i = 4; i < 6; i++)
      drive_check(1'b1, 1'b1, seqIn[i], 1'b1, seqOut[i], (i == 5), 1'b0, $sformatf("gap[%0d]", i));
    drive_check(1'b1, 1'b1, 77, 1'b0, 0, 1'b0, 1'b0, "gapAfter");

    // Reset mid-block with a coincident input, then a fresh block.
    do_reset(1'b0);
    bus.iOrder = 3'd6; bus.iBlockSize = 16'd5;
    drive_check(1'b1, 1'b1, 11, 1'b1, 11, 1'b0, 1'b1, "mid[0]");
    drive_check(1'b1, 1'b1, -22, 1'b1, -22, 1'b0, 1'b1, "mid[1]");
    do_reset(1'b1);
    bus.iOrder = 3'd1; bus.iBlockSize = 16'd3;
    drive_check(1'b1, 1'b1, 100, 1'b1, 100, 1'b0, 1'b0, "fresh[0]");
    drive_check(1'b1, 1'b1, 5,   1'b1, 105, 1'b0, 1'b0, "fresh[1]");
    drive_check(1'b1, 1'b1, -10, 1'b1, 95,  1'b1, 1'b0, "fresh[2]");

    // Randomized blocks with gaps and config changes after latching.
    for (int b = 0; b < 60; b++) begin
      do_reset($urandom_range(0, 1) == 1);
      bus.iOrder     = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                  : 3'($urandom_range(5, 7));
      bus.iBlockSize = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 14));
      for (int c = 0; c < 32; c++) begin
        en  = ($urandom_range(0, 5) != 0);
        vld = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 1) == 1) begin
          tmp = 16'($urandom);
          x = int'(tmp);
        end else begin
          x = int'($urandom_range(0, 100)) - 50;
        end
        model_step(en, vld, x, eV, eS, eD);
        drive_check(en, vld, x, eV, eS, eD, mErr, $sformatf("rnd%0d[%0d]", b, c));
        if (mStarted) begin
          bus.iOrder     = 3'($urandom_range(0, 7));
          bus.iBlockSize = 16'($urandom_range(0, 20));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
`default_nettype wire
